// File: rtl/cacheline_arbiter_pkg.sv
// Shared types and constants for the two-port cacheline arbiter.
package cacheline_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE   = 2'd1,
        RELEASE = 2'd2
    } arb_state_t;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

endpackage

// File: rtl/arb_port_mux.sv
// 2:1 selector of {address, write line} from the I-cache or D-cache port.
module arb_port_mux
    import cacheline_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
) (
    input  logic              i_grant,
    input  logic [ADDR_W-1:0] i_c0_address,
    input  logic [LINE_W-1:0] i_c0_wdata,
    input  logic [ADDR_W-1:0] i_c1_address,
    input  logic [LINE_W-1:0] i_c1_wdata,
    output logic [ADDR_W-1:0] o_address,
    output logic [LINE_W-1:0] o_wdata
);

    always_comb begin
        o_address = i_c0_address;
        o_wdata   = i_c0_wdata;
        if (i_grant == PORT_D) begin
            o_address = i_c1_address;
            o_wdata   = i_c1_wdata;
        end
    end

endmodule

// File: rtl/cacheline_arbiter.sv
// Round-robin arbiter sharing one cacheline adaptor between I-cache (port 0)
// and D-cache (port 1); one line transaction in flight at a time.
module cacheline_arbiter
    import cacheline_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] c0_address,
    input  logic              c0_read,
    input  logic              c0_write,
    input  logic [LINE_W-1:0] c0_wdata,
    output logic [LINE_W-1:0] c0_rdata,
    output logic              c0_resp,
    input  logic [ADDR_W-1:0] c1_address,
    input  logic              c1_read,
    input  logic              c1_write,
    input  logic [LINE_W-1:0] c1_wdata,
    output logic [LINE_W-1:0] c1_rdata,
    output logic              c1_resp,
    output logic [ADDR_W-1:0] mem_address,
    output logic [LINE_W-1:0] mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_resp,
    output arb_state_t        dbg_state
);

    // Cache side: level requests held until cX_resp. Adaptor side: mem_read /
    // mem_write held until the one-cycle mem_resp pulse, then dropped for one
    // RELEASE cycle before the next arbitration.
    arb_state_t r_state;
    logic       r_grant;
    logic       r_last;
    logic       r_op_write;
    logic       r_mem_read;
    logic       r_mem_write;

    logic w_req0;
    logic w_req1;
    logic w_pick;
    logic w_pick_write;
    logic w_done;

    assign w_req0 = c0_read | c0_write;
    assign w_req1 = c1_read | c1_write;
    // Tie goes to the port not served last; otherwise the lone requester.
    assign w_pick = (w_req0 & w_req1) ? ~r_last : w_req1;
    // Read wins if a port raises both read and write.
    assign w_pick_write = (w_pick == PORT_D) ? (c1_write & ~c1_read)
                                             : (c0_write & ~c0_read);
    assign w_done = (r_state == SERVE) & mem_resp;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_grant     <= PORT_I;
            r_last      <= PORT_D;
            r_op_write  <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_req0 | w_req1) begin
                        r_grant     <= w_pick;
                        r_op_write  <= w_pick_write;
                        r_mem_read  <= ~w_pick_write;
                        r_mem_write <= w_pick_write;
                        r_state     <= SERVE;
                    end
                end
                SERVE: begin
                    if (mem_resp) begin
                        r_last      <= r_grant;
                        r_mem_read  <= 1'b0;
                        r_mem_write <= 1'b0;
                        r_state     <= RELEASE;
                    end
                end
                RELEASE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_mem_read  <= 1'b0;
                    r_mem_write <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    arb_port_mux #(
        .ADDR_W (ADDR_W),
        .LINE_W (LINE_W)
    ) u_mux (
        .i_grant      (r_grant),
        .i_c0_address (c0_address),
        .i_c0_wdata   (c0_wdata),
        .i_c1_address (c1_address),
        .i_c1_wdata   (c1_wdata),
        .o_address    (mem_address),
        .o_wdata      (mem_wdata)
    );

    assign mem_read  = r_mem_read;
    assign mem_write = r_mem_write;
    assign c0_rdata  = mem_rdata;
    assign c1_rdata  = mem_rdata;
    assign c0_resp   = w_done & (r_grant == PORT_I);
    assign c1_resp   = w_done & (r_grant == PORT_D);
    assign dbg_state = r_state;

endmodule

// File: tb/tb_cacheline_arbiter.sv
// Directed, table-driven bench for cacheline_arbiter plus reset corner cases.
module tb_cacheline_arbiter;
    import cacheline_arbiter_pkg::*;

    localparam int ADDR_W = 32;
    localparam int LINE_W = 256;

    logic              clk;
    logic              reset;
    logic [ADDR_W-1:0] c0_address, c1_address, mem_address;
    logic              c0_read, c0_write, c1_read, c1_write;
    logic [LINE_W-1:0] c0_wdata, c1_wdata, c0_rdata, c1_rdata;
    logic              c0_resp, c1_resp;
    logic [LINE_W-1:0] mem_wdata, mem_rdata;
    logic              mem_read, mem_write, mem_resp;
    arb_state_t        dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [ADDR_W-1:0] A0 = 32'h0000_1000;
    localparam logic [ADDR_W-1:0] A1 = 32'h0000_2040;
    localparam logic [LINE_W-1:0] WD0 = {8{32'hDEADBEEF}};
    localparam logic [LINE_W-1:0] WD1 = {8{32'h01234567}};
    localparam logic [LINE_W-1:0] RD  = {32{8'hA5}};

    cacheline_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .c0_address  (c0_address),
        .c0_read     (c0_read),
        .c0_write    (c0_write),
        .c0_wdata    (c0_wdata),
        .c0_rdata    (c0_rdata),
        .c0_resp     (c0_resp),
        .c1_address  (c1_address),
        .c1_read     (c1_read),
        .c1_write    (c1_write),
        .c1_wdata    (c1_wdata),
        .c1_rdata    (c1_rdata),
        .c1_resp     (c1_resp),
        .mem_address (mem_address),
        .mem_wdata   (mem_wdata),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_rdata   (mem_rdata),
        .mem_resp    (mem_resp),
        .dbg_state   (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // in  = {c0_read, c0_write, c1_read, c1_write, mem_resp}
    // exp = {mem_read, mem_write, c0_resp, c1_resp}
    typedef struct {
        logic [4:0] in;
        logic [3:0] exp;
        logic [1:0] st;
        logic       gnt;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic [4:0] in, input logic [3:0] exp,
                       input logic [1:0] st, input logic gnt);
        vec_t v;
        v.in = in; v.exp = exp; v.st = st; v.gnt = gnt;
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input int idx,
                       input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s [%0d]: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic [4:0] in);
        {c0_read, c0_write, c1_read, c1_write, mem_resp} = in;
    endtask

    initial begin
        reset = 1'b1;
        c0_address = A0; c1_address = A1;
        c0_wdata = WD0;  c1_wdata = WD1;
        mem_rdata = RD;
        drive(5'b0);

        // Vectors are cycle-by-cycle from a fresh reset.
        add(5'b10000, 4'b0000, 2'd0, 1'b0); // 0  c0 read sampled in IDLE
        add(5'b10000, 4'b1000, 2'd1, 1'b0); // 1  SERVE, mem_read up
        add(5'b10001, 4'b1010, 2'd1, 1'b0); // 2  resp -> c0_resp
        add(5'b10000, 4'b0000, 2'd2, 1'b0); // 3  RELEASE (M+1)
        add(5'b10000, 4'b0000, 2'd0, 1'b0); // 4  IDLE (M+2)
        add(5'b10000, 4'b1000, 2'd1, 1'b0); // 5  back-to-back read (M+3)
        add(5'b10001, 4'b1010, 2'd1, 1'b0); // 6
        add(5'b00010, 4'b0000, 2'd2, 1'b0); // 7  c1 write pending
        add(5'b00010, 4'b0000, 2'd0, 1'b0); // 8  grant port 1
        add(5'b00011, 4'b0101, 2'd1, 1'b1); // 9  write, c1_resp
        add(5'b00000, 4'b0000, 2'd2, 1'b1); // 10 mem_write low
        add(5'b00001, 4'b0000, 2'd0, 1'b1); // 11 spurious resp in IDLE
        add(5'b00000, 4'b0000, 2'd0, 1'b1); // 12 still IDLE
        add(5'b10100, 4'b0000, 2'd0, 1'b1); // 13 tie, last=1 -> port 0
        add(5'b10101, 4'b1010, 2'd1, 1'b0); // 14
        add(5'b10100, 4'b0000, 2'd2, 1'b0); // 15
        add(5'b10100, 4'b0000, 2'd0, 1'b0); // 16 tie -> port 1
        add(5'b10101, 4'b1001, 2'd1, 1'b1); // 17
        add(5'b10100, 4'b0000, 2'd2, 1'b1); // 18
        add(5'b10100, 4'b0000, 2'd0, 1'b1); // 19 tie -> port 0
        add(5'b10101, 4'b1010, 2'd1, 1'b0); // 20
        add(5'b10100, 4'b0000, 2'd2, 1'b0); // 21
        add(5'b10100, 4'b0000, 2'd0, 1'b0); // 22 tie -> port 1
        add(5'b10101, 4'b1001, 2'd1, 1'b1); // 23
        add(5'b00000, 4'b0000, 2'd2, 1'b1); // 24

        // Reset state
        #2;
        chk("rst_outs", -1, {mem_read, mem_write, c0_resp, c1_resp}, 4'b0000);
        chk("rst_state", -1, dbg_state, 2'd0);
        chk("rst_addr", -1, mem_address, A0);
        chk("rst_wdata", -1, mem_wdata, WD0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        foreach (vq[i]) begin
            @(posedge clk);
            #1 drive(vq[i].in);
            #1;
            chk("outs", i, {mem_read, mem_write, c0_resp, c1_resp}, vq[i].exp);
            chk("state", i, dbg_state, vq[i].st);
            chk("addr", i, mem_address, vq[i].gnt ? A1 : A0);
            chk("wdata", i, mem_wdata, vq[i].gnt ? WD1 : WD0);
            if (vq[i].exp[1]) chk("c0_rdata", i, c0_rdata, RD);
            if (vq[i].exp[0]) chk("c1_rdata", i, c1_rdata, RD);
        end

        // Reset two cycles into SERVE, then tie after release.
        @(posedge clk);
        #1 reset = 1'b1;
        #1 reset = 1'b0;
        drive(5'b10100);
        @(posedge clk);
        #2 chk("rs_serve", 0, {mem_read, dbg_state}, {1'b1, 2'd1});
        @(posedge clk);
        #2 chk("rs_serve2", 0, {mem_read, dbg_state}, {1'b1, 2'd1});
        mem_resp = 1'b1;
        reset = 1'b1;
        #1;
        chk("rs_outs", 0, {mem_read, mem_write, c0_resp, c1_resp}, 4'b0000);
        chk("rs_state", 0, dbg_state, 2'd0);
        mem_resp = 1'b0;
        reset = 1'b0;
        @(posedge clk);
        #2;
        chk("rs_regrant", 0, {mem_read, dbg_state}, {1'b1, 2'd1});
        chk("rs_addr", 0, mem_address, A0);
        drive(5'b10101);
        #1 chk("rs_resp", 0, {c0_resp, c1_resp}, 2'b10);
        @(posedge clk);
        #1 drive(5'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
